decoded_instr_queue: RTL

// - Elastic FIFO between the decode stage and the scoreboard. Buffers decoded

---
 rtl/decoded_instr_queue.sv | 136 +++++++++++++
 1 files changed

// File: rtl/decoded_instr_queue.sv
// -----------------------------------------------------------------------------
// decoded_instr_queue
//
// Elastic FIFO between the decode stage and the scoreboard. It buffers decoded
// scoreboard entries and presents the oldest one on a valid/ack handshake.
// Decoder stalls are decoupled from scoreboard back-pressure. A separate
// counter tracks how many of the queued entries are control-flow instructions.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous reset, active-high
//   flush_i          drop every queued entry at the next edge
//   instr_i          decoded instruction from decode
//   instr_valid_i    instr_i is valid
//   is_ctrl_flow_i   instr_i is a branch/jump (qualified by instr_valid_i)
//   instr_ready_o    queue accepts instr_i this cycle
//   decoded_instr_o  oldest entry ('0 when empty)
//   decoded_valid_o  decoded_instr_o is valid
//   decoded_ack_i    scoreboard consumed decoded_instr_o
//   count_o          entries currently held (0..DEPTH)
//   ctrl_count_o     held entries flagged as control flow
// -----------------------------------------------------------------------------

package decoded_instr_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  trans_id;   // passed through untouched
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } scoreboard_entry_t;

endpackage

module decoded_instr_queue
  import decoded_instr_queue_pkg::*;
#(
  parameter  int unsigned DEPTH     = 4,
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  scoreboard_entry_t    instr_i,
  input  logic                 instr_valid_i,
  input  logic                 is_ctrl_flow_i,
  output logic                 instr_ready_o,
  output scoreboard_entry_t    decoded_instr_o,
  output logic                 decoded_valid_o,
  input  logic                 decoded_ack_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic [CNT_WIDTH-1:0] ctrl_count_o
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

  typedef struct packed {
    scoreboard_entry_t instr;
    logic              ctrl;
  } slot_t;

  slot_t                mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] ctrl_count_q, ctrl_count_d;

  logic push;
  logic pop;

  // Ready ignores decoded_ack_i on purpose: a full queue never accepts a push,
  // even in a cycle where it also pops, which keeps ready off the ack path.
  assign instr_ready_o   = (count_q != CNT_WIDTH'(DEPTH)) && !flush_i && !rst_i;
  assign decoded_valid_o = (count_q != '0);
  assign decoded_instr_o = decoded_valid_o ? mem_q[rd_ptr_q].instr : '0;
  assign count_o         = count_q;
  assign ctrl_count_o    = ctrl_count_q;

  assign push = instr_valid_i && instr_ready_o;
  assign pop  = decoded_valid_o && decoded_ack_i;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    ctrl_count_d = ctrl_count_q;
    if (flush_i) begin
      // Flush overrides any push or pop in the same cycle.
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      ctrl_count_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;  // wraps modulo DEPTH
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d      = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
      ctrl_count_d = ctrl_count_q
                   + CNT_WIDTH'(push && is_ctrl_flow_i)
                   - CNT_WIDTH'(pop && mem_q[rd_ptr_q].ctrl);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ctrl_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ctrl_count_q <= ctrl_count_d;
    end
  end

  // NOTE: storage has no reset; an entry is only observable once count_q
  // covers it, so clearing the array would cost flops and buy nothing.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{instr: instr_i, ctrl: is_ctrl_flow_i};
  end

`ifndef SYNTHESIS
  count_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= CNT_WIDTH'(DEPTH));
  ctrl_within_count: assert property (@(posedge clk_i) disable iff (rst_i)
    ctrl_count_q <= count_q);
`endif

endmodule
